// File: rtl/seq_det_pkg.sv
// Shared types and constants for the round-robin "1101" detector scheduler.
package seq_det_pkg;

  // Detector state encodings, visible on the debug port.
  typedef enum logic [2:0] {
    DET_S0 = 3'b000,
    DET_S1 = 3'b001,
    DET_S2 = 3'b010,
    DET_S3 = 3'b011,
    DET_S4 = 3'b100
  } det_state_t;

  // Controller phases: wait for a request, shift the frame, drain the
  // detector pipeline, then publish the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } ctrl_state_t;

  // Zero-input cycles after the last frame bit: one for the detector state
  // register and one for its registered output.
  localparam int FLUSH_LEN = 2;

endpackage

// File: rtl/seq_det_core.sv
// Serial Moore detector for the pattern 1101. Matches do not overlap: after
// a hit the search restarts, so a following 1 only counts as a first 1.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       din,
  output logic       dout,
  output logic [2:0] state
);

  det_state_t state_q, state_d;
  logic       dout_q;

  // Next-state function of the pattern FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DET_S0:  state_d = din ? DET_S1 : DET_S0;
      DET_S1:  state_d = din ? DET_S2 : DET_S0;
      DET_S2:  state_d = din ? DET_S2 : DET_S3;
      DET_S3:  state_d = din ? DET_S4 : DET_S0;
      DET_S4:  state_d = din ? DET_S1 : DET_S0;
      default: state_d = DET_S0;
    endcase
  end

  // State and registered hit flag; clr forces a clean start synchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DET_S0;
      dout_q  <= 1'b0;
    end else if (clr) begin
      state_q <= DET_S0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= (state_q == DET_S4);
    end
  end

  assign dout  = dout_q;
  assign state = state_q;

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial 1101 detector among NREQ frame
// producers. A granted frame is shifted MSB-first into the detector, hits
// are counted (saturating) and reported with the requester id.
// Handshake: req[i] is a level sampled only while idle; grant[i] is a
// one-cycle acceptance pulse after which the requester drops req[i] (or
// keeps it high with its next frame). done is a one-cycle valid pulse for
// done_id/match_count, which then hold until the next done.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FRAME_W-1:0] frame_data,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [CNT_W-1:0]        match_count,
  output logic [2:0]              det_state
);

  localparam int ID_W = $clog2(NREQ);
  localparam int BC_W = $clog2(FRAME_W);
  localparam int FL_W = $clog2(FLUSH_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_t       state_q;
  logic [FRAME_W-1:0] sr_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [FL_W-1:0]   flush_cnt_q;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [ID_W-1:0]   winner_q, rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, done_q;
  logic [ID_W-1:0]   done_id_q;
  logic [CNT_W-1:0]  match_count_q;

  logic [ID_W-1:0]    win_d, idx;
  logic               any_req;
  logic [FRAME_W-1:0] win_frame;
  logic               det_din, det_clr, det_dout;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    win_d   = rr_ptr_q;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(rr_ptr_q) + k >= NREQ) idx = ID_W'(int'(rr_ptr_q) + k - NREQ);
      else                            idx = ID_W'(int'(rr_ptr_q) + k);
      if (!any_req && req[idx]) begin
        win_d   = idx;
        any_req = 1'b1;
      end
    end
  end

  // Winner's frame and its one-hot grant vector.
  always_comb begin
    win_frame = '0;
    grant_d   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == win_d) begin
        win_frame  = frame_data[k*FRAME_W +: FRAME_W];
        grant_d[k] = 1'b1;
      end
    end
  end

  // Saturating hit count and the pointer value after this winner.
  always_comb begin
    hit_d = hit_q;
    if ((state_q == SHIFT || state_q == FLUSH) && det_dout && hit_q != CNT_MAX)
      hit_d = hit_q + CNT_W'(1);
    rr_ptr_d = (winner_q == ID_W'(NREQ - 1)) ? '0 : winner_q + ID_W'(1);
  end

  assign det_din = (state_q == SHIFT) ? sr_q[FRAME_W-1] : 1'b0;
  assign det_clr = (state_q == IDLE);

  seq_det_core u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (det_clr),
    .din   (det_din),
    .dout  (det_dout),
    .state (det_state)
  );

  // Controller FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      hit_q         <= '0;
      winner_q      <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_id_q     <= '0;
      match_count_q <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            sr_q      <= win_frame;
            bit_cnt_q <= '0;
            hit_q     <= '0;
            winner_q  <= win_d;
            grant_q   <= grant_d;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q      <= sr_q << 1;
          hit_q     <= hit_d;
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == BC_W'(FRAME_W - 1)) begin
            flush_cnt_q <= '0;
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          hit_q       <= hit_d;
          flush_cnt_q <= flush_cnt_q + FL_W'(1);
          if (flush_cnt_q == FL_W'(FLUSH_LEN - 1)) begin
            done_q        <= 1'b1;
            done_id_q     <= winner_q;
            match_count_q <= hit_d;
            state_q       <= REPORT;
          end
        end
        REPORT: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed cases plus random
// request/frame traffic, with a scoreboard fed by the stimulus side and
// drained by a monitor on grant/done.
module tb_seq_det_sched;

  localparam int NREQ = 4;
  localparam int FW   = 8;
  localparam int CW   = 4;
  localparam int IDW  = 2;
  localparam int SFW  = 32;
  localparam int SCW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic [NREQ-1:0]    req;
  logic [NREQ*FW-1:0] frame_data;
  logic [NREQ-1:0]    grant;
  logic               busy, done;
  logic [IDW-1:0]     done_id;
  logic [CW-1:0]      match_count;
  logic [2:0]         det_state;

  seq_det_sched #(.NREQ(NREQ), .FRAME_W(FW), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .req(req), .frame_data(frame_data),
    .grant(grant), .busy(busy), .done(done), .done_id(done_id),
    .match_count(match_count), .det_state(det_state)
  );

  // ---------------- saturation DUT ----------------
  logic [1:0]       req_s;
  logic [2*SFW-1:0] frame_s;
  logic [1:0]       grant_s;
  logic             busy_s, done_s;
  logic [0:0]       done_id_s;
  logic [SCW-1:0]   match_s;
  logic [2:0]       det_s;

  seq_det_sched #(.NREQ(2), .FRAME_W(SFW), .CNT_W(SCW)) u_sat (
    .clk(clk), .reset(reset), .req(req_s), .frame_data(frame_s),
    .grant(grant_s), .busy(busy_s), .done(done_s), .done_id(done_id_s),
    .match_count(match_s), .det_state(det_s)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [NREQ-1:0]   exp_grant_q[$];
  logic [IDW+CW-1:0] exp_q[$];
  int                gcyc_q[$];
  int                prev_g = 0;
  int                last_g = 0;
  int                ptr_m  = 0;

  logic [NREQ-1:0] req_v = '0;
  logic [FW-1:0]   fr [NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Non-overlapping left-to-right count of 1101 in the top w bits, saturated.
  function automatic int ref_hits(input logic [31:0] f, input int w, input int cw);
    int cnt = 0;
    int i   = w - 1;
    while (i >= 3) begin
      if (f[i] && f[i-1] && !f[i-2] && f[i-3]) begin
        cnt++;
        i -= 4;
      end else begin
        i--;
      end
    end
    if (cnt > (1 << cw) - 1) cnt = (1 << cw) - 1;
    return cnt;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    req = req_v;
    for (int i = 0; i < NREQ; i++) frame_data[i*FW +: FW] = fr[i];
  endtask

  // Called #1 after an edge into an IDLE cycle with req_v != 0. Returns #1
  // after the edge into the next IDLE cycle.
  // mode: 0 plain, 1 random traffic, 2 req[1] raised/withdrawn, 3 all-ones
  // detector state check, 4 winner keeps its request.
  task automatic issue_one(input int mode);
    int w;
    logic [NREQ-1:0] g;
    w = rr_pick(req_v, ptr_m);
    g = '0;
    g[w] = 1'b1;
    exp_grant_q.push_back(g);
    exp_q.push_back({IDW'(w), CW'(ref_hits(32'(fr[w]), FW, CW))});
    ptr_m = (w + 1) % NREQ;
    @(posedge clk); #1;
    if (mode != 4) begin
      req_v[w] = 1'b0;
      drive();
    end
    for (int j = 1; j <= FW + 3; j++) begin
      @(negedge clk);
      chk("busy_in_frame", busy, 1);
      if (mode == 3 && j - 1 >= 2 && j - 1 <= FW) chk("det_state_s2", det_state, 3'b010);
      @(posedge clk); #1;
      if (mode == 1) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_v[i] && $urandom_range(0, 3) == 0) begin
            fr[i]    = FW'($urandom);
            req_v[i] = 1'b1;
          end else if (req_v[i] && $urandom_range(0, 15) == 0) begin
            req_v[i] = 1'b0;
          end
        end
      end
      if (mode == 2 && j == 3) begin
        fr[1]    = FW'($urandom);
        req_v[1] = 1'b1;
      end
      if (mode == 2 && j == 6) req_v[1] = 1'b0;
      drive();
    end
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [NREQ-1:0]   eg;
    logic [IDW+CW-1:0] er;
    int gc;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (grant != '0) begin
          if (exp_grant_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_grant: got %b expected none", grant);
          end else begin
            eg = exp_grant_q.pop_front();
            chk("grant", grant, eg);
          end
          chk("grant_done_overlap", done, 0);
          gcyc_q.push_back(cyc);
          prev_g = last_g;
          last_g = cyc;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got id %0d expected none", done_id);
          end else begin
            er = exp_q.pop_front();
            chk("done_id", done_id, er[CW +: IDW]);
            chk("match_count", match_count, er[CW-1:0]);
            if (gcyc_q.size() != 0) begin
              gc = gcyc_q.pop_front();
              chk("done_latency", cyc - gc, FW + 2);
            end
          end
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] sat_frame;
    bit got;
    for (int i = 0; i < NREQ; i++) fr[i] = '0;
    req_v   = '0;
    req_s   = '0;
    frame_s = '0;
    drive();
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values.
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match", match_count, 0);
    chk("rst_det_state", det_state, 0);
    chk("rst_sat_busy", busy_s, 0);

    // Saturation: 32-bit frame of eight 1101 groups, 2-bit counter.
    @(posedge clk); #1;
    sat_frame = {8{4'b1101}};
    frame_s[SFW-1:0] = sat_frame;
    req_s = 2'b01;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (grant_s != 2'b00) got = 1;
    end
    chk("sat_grant_seen", got, 1);
    chk("sat_grant", grant_s, 2'b01);
    req_s = 2'b00;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done_s) got = 1;
    end
    chk("sat_done_seen", got, 1);
    chk("sat_match", match_s, ref_hits(sat_frame, SFW, SCW));
    chk("sat_done_id", done_id_s, 0);
    @(posedge clk); #1;

    // Requester 0, 1101_1101: two hits.
    fr[0] = 8'b1101_1101; req_v = 4'b0001; drive();
    issue_one(0);
    @(negedge clk);
    chk("tp1_match", match_count, 2);
    chk("tp1_id", done_id, 0);
    @(posedge clk); #1;

    // Requester 2, 0110_1000: one hit.
    fr[2] = 8'b0110_1000; req_v = 4'b0100; drive();
    issue_one(0);
    @(negedge clk);
    chk("tp2_match", match_count, 1);
    @(posedge clk); #1;

    // Requester 1, all ones: no hit, detector parked in S2.
    fr[1] = 8'hFF; req_v = 4'b0010; drive();
    issue_one(3);
    @(negedge clk);
    chk("tp3_match", match_count, 0);
    @(posedge clk); #1;

    // req[1] raised and withdrawn during requester 0's frame.
    fr[0] = FW'($urandom); req_v = 4'b0001; drive();
    issue_one(2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("withdraw_idle_busy", busy, 0);
      chk("withdraw_no_grant", grant, 0);
    end
    @(posedge clk); #1;

    // Reset, then all four requesting continuously: order 0,1,2,3,0.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < NREQ; i++) fr[i] = FW'($urandom);
    req_v = 4'b1111; drive();
    for (int n = 0; n < 5; n++) begin
      issue_one(4);
      if (n > 0) chk("rr_spacing", last_g - prev_g, FW + 4);
    end
    req_v = '0; drive();
    @(posedge clk); #1;

    // Reset during SHIFT bit 4 of requester 2's frame.
    fr[2] = FW'($urandom); req_v = 4'b0100; drive();
    exp_grant_q.push_back(4'b0100);
    @(posedge clk); #1;
    req_v = '0; drive();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ptr_m = 0;
    gcyc_q.delete();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_idle_busy", busy, 0);
    end
    @(posedge clk); #1;
    fr[0] = FW'($urandom); fr[3] = FW'($urandom);
    req_v = 4'b1001; drive();
    issue_one(0);
    issue_one(0);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      if (req_v == '0) begin
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            fr[i]    = FW'($urandom);
            req_v[i] = 1'b1;
          end
        end
        drive();
      end else begin
        issue_one(1);
      end
    end
    req_v = '0; drive();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("grant_queue_empty", exp_grant_q.size(), 0);
    chk("result_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
